// File: rtl/hazard3_cdc_pkg.sv
// Definitions shared by the source and destination halves of the hazard3
// 4-phase req/ack clock-domain crossing.
package hazard3_cdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } cdc_state_e;

    // Synchroniser depth used by both sides unless a parent overrides it.
    localparam int DEFAULT_N_SYNC_STAGES = 2;

endpackage

// File: rtl/hazard3_sync_1bit.sv
// Multi-flop level synchroniser for one asynchronous bit.
// The output lags the input by N_STAGES rising edges of clk.
module hazard3_sync_1bit
    import hazard3_cdc_pkg::*;
#(
    parameter int N_STAGES = DEFAULT_N_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (N_STAGES < 2) begin : g_bad_depth
        $error("hazard3_sync_1bit: N_STAGES must be at least 2");
    end

    logic [N_STAGES-1:0] stages;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples its predecessor's pre-edge value; blocking would collapse it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[N_STAGES-2:0], d};
        end
    end

    assign q = stages[N_STAGES-1];

endmodule

// File: rtl/hazard3_cdc_handshake_dst.sv
// Destination half of a 4-phase req/ack CDC: synchronises src_req, captures
// src_data into a valid/ready output and returns a registered ack level.
// Optional macro HAZARD3_CDC_HANDSHAKE_EARLY_ACK_EN acknowledges on capture.
module hazard3_cdc_handshake_dst
    import hazard3_cdc_pkg::*;
#(
    parameter int W_DATA        = 32,
    parameter int N_SYNC_STAGES = DEFAULT_N_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_req,
    input  logic [W_DATA-1:0] src_data,
    output logic              dst_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_DATA-1:0] out_data
);

    logic       req_s;
    cdc_state_e state;

    // src_data is deliberately not synchronised: the source holds it stable
    // from before src_req rises until it has seen dst_ack.
    hazard3_sync_1bit #(
        .N_STAGES (N_SYNC_STAGES)
    ) u_sync_req (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (src_req),
        .q     (req_s)
    );

`ifdef HAZARD3_CDC_HANDSHAKE_EARLY_ACK_EN

    // Two-state variant: the source is released at capture, so the output
    // register acts as a one-word buffer drained independently of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dst_ack   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    // A new word may only land once the old one leaves this edge.
                    if (req_s && (!out_valid || out_ready)) begin
                        out_data  <= src_data;
                        out_valid <= 1'b1;
                        dst_ack   <= 1'b1;
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        dst_ack <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    dst_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`else

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dst_ack   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    dst_ack <= 1'b0;
                    if (req_s) begin
                        out_data  <= src_data;
                        out_valid <= 1'b1;
                        state     <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    // A req drop here is a source bug; still finish the transfer.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        dst_ack   <= 1'b1;
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        dst_ack <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    dst_ack   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // The source must keep src_req high until it has observed dst_ack.
    a_req_held_in_valid : assert property (
        @(posedge clk) disable iff (!rst_n) (state == ST_VALID) |-> req_s
    );

`endif

endmodule

// File: tb/tb_hazard3_cdc_handshake_dst.sv
// Bench for hazard3_cdc_handshake_dst: transaction-level protocol model plus
// directed transfers; honours HAZARD3_CDC_HANDSHAKE_EARLY_ACK_EN when defined.
`timescale 1ns/1ps
module tb_hazard3_cdc_handshake_dst;

    localparam int W_DATA = 32;
    localparam int N_SYNC = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              src_req;
    logic [W_DATA-1:0] src_data;
    logic              dst_ack;
    logic              out_valid;
    logic              out_ready;
    logic [W_DATA-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    hazard3_cdc_handshake_dst #(
        .W_DATA        (W_DATA),
        .N_SYNC_STAGES (N_SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_req   (src_req),
        .src_data  (src_data),
        .dst_ack   (dst_ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: req_s is src_req as sampled N_SYNC edges earlier; the
    // output word, its valid flag and the ack level follow the handshake rules.
    bit          m_valid = 1'b0;
    bit          m_ack   = 1'b0;
    logic [31:0] m_data  = '0;
    bit          req_q[$];
    bit          rs, take, cap, rel;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                req_q.delete();
                m_valid = 1'b0;
                m_ack   = 1'b0;
                m_data  = '0;
            end else begin
                rs = (req_q.size() >= N_SYNC) ? req_q[req_q.size()-N_SYNC] : 1'b0;
                req_q.push_back(src_req);
                if (req_q.size() > N_SYNC) void'(req_q.pop_front());
                take = m_valid && out_ready;
                rel  = m_ack && !rs;
`ifdef HAZARD3_CDC_HANDSHAKE_EARLY_ACK_EN
                cap = rs && !m_ack && (!m_valid || out_ready);
                if (take) m_valid = 1'b0;
                if (cap) begin
                    m_data  = src_data;
                    m_valid = 1'b1;
                    m_ack   = 1'b1;
                end
                if (rel) m_ack = 1'b0;
`else
                cap = rs && !m_ack && !m_valid;
                if (take) begin
                    m_valid = 1'b0;
                    m_ack   = 1'b1;
                end else if (rel) begin
                    m_ack = 1'b0;
                end else if (cap) begin
                    m_data  = src_data;
                    m_valid = 1'b1;
                end
`endif
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cmp_dst_ack",   dst_ack,   m_ack);
            check("cmp_out_valid", out_valid, m_valid);
            check("cmp_out_data",  out_data,  m_data);
        end
    end

    // Record every accepted word; sampled at negedge, it completes next posedge.
    logic [31:0] hs_q[$];
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) hs_q.push_back(out_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic level, input string name);
        int n = 0;
        while (dst_ack !== level && n < 40) begin
            tick();
            n++;
        end
        check(name, dst_ack, level);
    endtask

    task automatic wait_valid(input logic level, input string name);
        int n = 0;
        while (out_valid !== level && n < 40) begin
            tick();
            n++;
        end
        check(name, out_valid, level);
    endtask

    task automatic xfer(input logic [31:0] data, input string name);
        src_data = data;
        src_req  = 1'b1;
        wait_ack(1'b1, {name, "_ack_rise"});
        src_req = 1'b0;
        wait_ack(1'b0, {name, "_ack_fall"});
    endtask

    initial begin
        rst_n     = 1'b0;
        src_req   = 1'b0;
        src_data  = '0;
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_dst_ack",   dst_ack,   1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

`ifdef HAZARD3_CDC_HANDSHAKE_EARLY_ACK_EN
        out_ready = 1'b1;
        xfer(32'h5, "early_warmup");
        tick();
        check("early_warmup_drained", out_valid, 1'b0);

        // Early ack with a stalled consumer.
        hs_q.delete();
        out_ready = 1'b0;
        src_data  = 32'hA;
        src_req   = 1'b1;
        wait_valid(1'b1, "early_a_valid");
        check("early_ack_on_capture", dst_ack, 1'b1);
        src_req = 1'b0;
        wait_ack(1'b0, "early_a_ack_fall");
        src_data = 32'hB;
        src_req  = 1'b1;
        repeat (8) tick();
        check("early_stall_data", out_data,  32'hA);
        check("early_stall_ack",  dst_ack,   1'b0);
        check("early_stall_vld",  out_valid, 1'b1);
        out_ready = 1'b1;
        wait_ack(1'b1, "early_b_ack_rise");
        src_req = 1'b0;
        wait_ack(1'b0, "early_b_ack_fall");
        repeat (2) tick();
        check("early_hs_count", hs_q.size(), 2);
        if (hs_q.size() == 2) begin
            check("early_hs_word0", hs_q[0], 32'hA);
            check("early_hs_word1", hs_q[1], 32'hB);
        end
`else
        // Basic transfer with literal timing: src_req rises just after edge 0.
        src_data  = 32'hDEADBEEF;
        out_ready = 1'b1;
        src_req   = 1'b1;
        tick();
        check("basic_e1_valid", out_valid, 1'b0);
        tick();
        check("basic_e2_valid", out_valid, 1'b0);
        tick();
        check("basic_e3_valid", out_valid, 1'b1);
        check("basic_e3_data",  out_data,  32'hDEADBEEF);
        check("basic_e3_ack",   dst_ack,   1'b0);
        tick();
        check("basic_e4_ack",   dst_ack,   1'b1);
        check("basic_e4_valid", out_valid, 1'b0);
        src_req = 1'b0;
        tick();
        tick();
        check("basic_drop_e2_ack", dst_ack, 1'b1);
        tick();
        check("basic_drop_e3_ack", dst_ack, 1'b0);
        repeat (2) tick();

        // Backpressure: word and flags held until the consumer is ready.
        out_ready = 1'b0;
        src_data  = 32'h12345678;
        src_req   = 1'b1;
        wait_valid(1'b1, "bp_valid_rise");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_data",  out_data,  32'h12345678);
            check("bp_hold_ack",   dst_ack,   1'b0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ack",   dst_ack,   1'b1);
        check("bp_release_valid", out_valid, 1'b0);
        src_req = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");
        repeat (2) tick();

        // Back-to-back words over full handshakes.
        hs_q.delete();
        xfer(32'h1, "b2b_w1");
        xfer(32'h2, "b2b_w2");
        repeat (4) tick();
        check("b2b_hs_count", hs_q.size(), 2);
        if (hs_q.size() == 2) begin
            check("b2b_hs_word0", hs_q[0], 32'h1);
            check("b2b_hs_word1", hs_q[1], 32'h2);
        end

        // Reset while holding a word, src_req still high: duplicate capture.
        out_ready = 1'b0;
        src_data  = 32'hCAFEF00D;
        src_req   = 1'b1;
        wait_valid(1'b1, "rstmid_valid_rise");
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_ack",   dst_ack,   1'b0);
        check("rstmid_valid", out_valid, 1'b0);
        check("rstmid_data",  out_data,  32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstmid_e1_valid", out_valid, 1'b0);
        tick();
        check("rstmid_e2_valid", out_valid, 1'b0);
        tick();
        check("rstmid_e3_valid", out_valid, 1'b1);
        check("rstmid_e3_data",  out_data,  32'hCAFEF00D);
        out_ready = 1'b1;
        wait_ack(1'b1, "rstmid_ack_rise");
        src_req = 1'b0;
        wait_ack(1'b0, "rstmid_ack_fall");
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
